// File: rtl/universal_shift_register.sv
// universal_shift_register: 8-mode shift/rotate/load register with a burst serialiser and abort
module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       mode,
    input  logic             shift_en,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    bit_count
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] data_nxt, op;
    logic [CW-1:0] cnt_nxt;
    logic done_nxt;
    always_comb begin
        case (mode)
            3'b000:  op = data_out;
            3'b001:  op = {data_out[WIDTH-2:0], serial_in};
            3'b010:  op = {serial_in, data_out[WIDTH-1:1]};
            3'b011:  op = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
            3'b100:  op = {data_out[0], data_out[WIDTH-1:1]};
            3'b101:  op = data_in;
            3'b110:  op = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
            default: op = '0;
        endcase
    end
    // abort wins over the final shift, so it is tested before any shift in BURST
    always_comb begin
        state_nxt = state;
        data_nxt  = data_out;
        cnt_nxt   = bit_count;
        done_nxt  = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                data_nxt  = data_in;
                cnt_nxt   = '0;
                state_nxt = BURST;
            end else if (shift_en) begin
                data_nxt = op;
            end
        end else if (abort) begin
            state_nxt = IDLE;
        end else begin
            data_nxt = {data_out[WIDTH-2:0], serial_in};
            cnt_nxt  = bit_count + 1'b1;
            if (bit_count == CW'(WIDTH - 1)) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            data_out  <= RESET_VALUE;
            bit_count <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            data_out  <= data_nxt;
            bit_count <= cnt_nxt;
            done      <= done_nxt;
        end
    end
    assign busy       = (state == BURST);
    assign serial_out = data_out[WIDTH-1];
endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: randomized scoreboard bench against an arithmetic reference model
module tb_universal_shift_register;
    localparam int W = 8;
    logic clk = 1'b0, reset_n = 1'b0;
    logic [2:0] mode = '0;
    logic shift_en = 1'b0, serial_in = 1'b0, start = 1'b0, abort = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] data_out;
    logic serial_out, busy, done;
    logic [3:0] bit_count;

    always #5 clk = ~clk;

    universal_shift_register #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .shift_en(shift_en),
        .serial_in(serial_in), .data_in(data_in), .start(start), .abort(abort),
        .data_out(data_out), .serial_out(serial_out), .busy(busy), .done(done),
        .bit_count(bit_count)
    );

    typedef struct packed {logic [7:0] d; logic b; logic dn; logic [3:0] c;} exp_t;
    exp_t q[$];
    exp_t e;
    int n_cmp = 0, n_bad = 0;
    int m_d = 0, m_cnt = 0;
    bit m_busy = 0, m_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: plain integer arithmetic on the register value, burst tracked as shifts done
    function automatic void model(input int md, input bit se, input bit si, input bit st, input bit ab, input int din);
        m_done = 0;
        if (!m_busy) begin
            if (st) begin
                m_d = din; m_cnt = 0; m_busy = 1;
            end else if (se) begin
                case (md)
                    1: m_d = (m_d * 2 + si) % 256;
                    2: m_d = m_d / 2 + si * 128;
                    3: m_d = (m_d * 2) % 256 + m_d / 128;
                    4: m_d = m_d / 2 + (m_d % 2) * 128;
                    5: m_d = din;
                    6: m_d = m_d / 2 + (m_d / 128) * 128;
                    7: m_d = 0;
                    default: ;
                endcase
            end
        end else if (ab) begin
            m_busy = 0;
        end else begin
            m_d = (m_d * 2 + si) % 256;
            m_cnt++;
            if (m_cnt == W) begin m_busy = 0; m_done = 1; end
        end
    endfunction

    task automatic step(input int md, input bit se, input bit si, input bit st, input bit ab, input int din);
        @(negedge clk);
        mode = md[2:0]; shift_en = se; serial_in = si; start = st; abort = ab; data_in = din[7:0];
        @(posedge clk);
        model(md, se, si, st, ab, din);
        q.push_back(exp_t'{d: m_d[7:0], b: m_busy, dn: m_done, c: m_cnt[3:0]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("data_out", data_out, e.d);
            check("serial_out", serial_out, e.d[7]);
            check("busy", busy, e.b);
            check("done", done, e.dn);
            check("bit_count", bit_count, e.c);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [7:0] bits;
    logic [15:0] sbits;
    int lowc, dcnt;

    initial begin
        #1;
        check("rst data_out", data_out, 8'h00);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst bit_count", bit_count, 0);
        #20;
        @(negedge clk) reset_n = 1'b1;

        step(5, 1, 0, 0, 0, 'hB4); #2 check("load", data_out, 8'hB4);
        step(1, 1, 1, 0, 0, 0);    #2 check("shl", data_out, 8'h69);
        step(4, 1, 0, 0, 0, 0);    #2 check("ror", data_out, 8'hB4);
        step(6, 1, 0, 0, 0, 0);    #2 check("asr", data_out, 8'hDA);
        step(7, 1, 0, 0, 0, 0);    #2 check("clear", data_out, 8'h00);
        step(5, 1, 0, 0, 0, 'h81);
        step(7, 0, 0, 0, 0, 0);    #2 check("hold", data_out, 8'h81);
        step(3, 1, 0, 0, 0, 0);    #2 check("rol", data_out, 8'h03);
        step(2, 1, 1, 0, 0, 0);    #2 check("shr", data_out, 8'h81);
        step(0, 1, 0, 0, 0, 0);    #2 check("mode hold", data_out, 8'h81);

        step(0, 0, 0, 1, 0, 'hA5); #2 bits[7] = serial_out;
        for (int i = 6; i >= 0; i--) begin
            step(0, 0, 0, 0, 0, 0); #2 bits[i] = serial_out;
            check("no early done", done, 0);
        end
        step(0, 0, 0, 0, 0, 0); #2;
        check("burst bits", bits, 8'hA5);
        check("burst done", done, 1);
        check("burst count", bit_count, 8);
        check("burst data", data_out, 8'h00);
        step(0, 0, 0, 0, 0, 0); #2 check("done one cycle", done, 0);

        sbits = '0; lowc = 0; dcnt = 0;
        step(0, 0, 0, 1, 0, 'hFF);
        for (int i = 0; i < 18; i++) begin
            #2;
            if (busy) sbits = {sbits[14:0], serial_out};
            if (!busy && i < 17) lowc++;
            if (done) dcnt++;
            if (i < 17) step(0, 0, 0, 1, 0, 'h0F);
        end
        step(0, 0, 0, 0, 0, 0);
        check("b2b bits", sbits, 16'hFF0F);
        check("b2b busy low", lowc, 1);
        check("b2b done pulses", dcnt, 2);

        step(0, 0, 0, 1, 0, 'hA5);
        idle(3);
        step(0, 0, 0, 0, 1, 0); #2;
        check("abort busy", busy, 0);
        check("abort count", bit_count, 3);
        check("abort data", data_out, 8'h28);
        idle(10);

        step(0, 0, 0, 1, 0, 'h3C);
        idle(7);
        step(0, 0, 0, 0, 1, 0); #2;
        check("late abort done", done, 0);
        check("late abort count", bit_count, 7);
        step(0, 0, 0, 0, 0, 0); #2 check("late abort no done", done, 0);
        step(1, 1, 1, 0, 1, 0);

        step(7, 1, 0, 1, 0, 'hC3); #2;
        check("start over mode", data_out, 8'hC3);
        check("start busy", busy, 1);
        idle(2);
        @(negedge clk); #2 reset_n = 1'b0; #1;
        check("async rst data", data_out, 8'h00);
        check("async rst busy", busy, 0);
        check("async rst done", done, 0);
        check("async rst count", bit_count, 0);
        m_d = 0; m_cnt = 0; m_busy = 0; m_done = 0;
        @(negedge clk) reset_n = 1'b1;
        idle(12);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 7), 1'($urandom % 2), 1'($urandom % 2),
                 ($urandom % 8) == 0, ($urandom % 16) == 0, $urandom_range(0, 255));
        @(posedge clk); #2;
        check("queue drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
